mem_sequencer: RTL and testbench

Sequencer that drives the 2-bit `memoryena` code into the memory decoder (`MemInterpreter`), moving one frame through three phases: FILL, PROCESS and DRAIN. In FILL, deserializer words are written into block1. In PROCESS, block1 is copied into block2. In DRAIN, block2 is read out to the serializer. It also supplies the shared read/write addresses and the frame-level status seen by the top level.

---
 rtl/mem_sequencer.sv | 133 +++++++++++++
 tb/tb_mem_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// Frame sequencer for the block1/block2 memory pair: FILL writes block1, PROCESS copies
// block1 into block2, DRAIN reads block2 out, all steered through the 2-bit memoryena code.
module mem_sequencer #(
    parameter int ADDR_WIDTH  = 10,
    parameter int BLOCK_DEPTH = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  deser_valid,
    input  logic                  ser_ready,
    output logic [1:0]            memoryena,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frame_count
);

    // One extra bit because PROCESS indexes k up to BLOCK_DEPTH, which may equal 2^ADDR_WIDTH.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST      = CW'(BLOCK_DEPTH - 1);
    localparam logic [CW-1:0] PROC_LAST = CW'(BLOCK_DEPTH);

    localparam logic [1:0] ENA_IDLE    = 2'b00;
    localparam logic [1:0] ENA_FILL    = 2'b01;
    localparam logic [1:0] ENA_PROCESS = 2'b11;
    localparam logic [1:0] ENA_DRAIN   = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PROCESS,
        DRAIN
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;

    assign count_inc = count + CW'(1);

    // Outputs are loaded with the values of the state being entered, so they are all registered.
    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            memoryena   <= ENA_IDLE;
            rd_addr     <= '0;
            wr_addr     <= '0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else if (abort) begin
            state     <= IDLE;
            count     <= '0;
            memoryena <= ENA_IDLE;
            rd_addr   <= '0;
            wr_addr   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FILL;
                        count     <= '0;
                        memoryena <= ENA_FILL;
                        rd_addr   <= '0;
                        wr_addr   <= '0;
                        busy      <= 1'b1;
                    end
                end

                FILL: begin
                    if (deser_valid) begin
                        if (count == LAST) begin
                            state     <= PROCESS;
                            count     <= '0;
                            memoryena <= ENA_PROCESS;
                            rd_addr   <= '0;
                            wr_addr   <= '0;
                        end else begin
                            count   <= count_inc;
                            wr_addr <= ADDR_WIDTH'(count_inc);
                        end
                    end
                end

                // Write trails read by one cycle to cover the block RAM read latency.
                PROCESS: begin
                    if (count == PROC_LAST) begin
                        state     <= DRAIN;
                        count     <= '0;
                        memoryena <= ENA_DRAIN;
                        rd_addr   <= '0;
                        wr_addr   <= '0;
                    end else begin
                        count   <= count_inc;
                        rd_addr <= (count_inc > LAST) ? ADDR_WIDTH'(LAST) : ADDR_WIDTH'(count_inc);
                        wr_addr <= ADDR_WIDTH'(count);
                    end
                end

                DRAIN: begin
                    if (ser_ready) begin
                        if (count == LAST) begin
                            state       <= IDLE;
                            count       <= '0;
                            memoryena   <= ENA_IDLE;
                            rd_addr     <= '0;
                            wr_addr     <= '0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            count   <= count_inc;
                            rd_addr <= ADDR_WIDTH'(count_inc);
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    count     <= '0;
                    memoryena <= ENA_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_sequencer.sv
// Scoreboard bench for mem_sequencer: a phase/index reference model queues the expected
// outputs for every cycle and a monitor compares them against the DUT.
module tb_mem_sequencer;

    localparam int ADDR_WIDTH = 2;
    localparam int DEPTH      = 4;

    localparam int P_IDLE    = 0;
    localparam int P_FILL    = 1;
    localparam int P_PROCESS = 2;
    localparam int P_DRAIN   = 3;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic                  abort = 1'b0;
    logic                  deser_valid = 1'b0;
    logic                  ser_ready = 1'b0;
    logic [1:0]            memoryena;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  busy;
    logic                  done;
    logic [7:0]            frame_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int ena;
        int rd;
        int wr;
        bit chk_rd;
        bit chk_wr;
        int busy;
        int done;
        int fc;
    } exp_t;

    exp_t expq[$];
    exp_t m_exp;
    exp_t got;

    int m_phase = P_IDLE;
    int m_idx   = 0;
    int m_fc    = 0;
    bit m_done  = 1'b0;

    mem_sequencer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BLOCK_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .deser_valid(deser_valid),
        .ser_ready  (ser_ready),
        .memoryena  (memoryena),
        .rd_addr    (rd_addr),
        .wr_addr    (wr_addr),
        .busy       (busy),
        .done       (done),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit a, input bit s, input bit dv, input bit sr);
        @(negedge clk);
        reset       = r;
        abort       = a;
        start       = s;
        deser_valid = dv;
        ser_ready   = sr;
        @(posedge clk);
        #1;
    endtask

    // Latency uses the cycle numbering where the cycle after the start-sampling edge is 1.
    task automatic runFrame(input bit holdStart, input bit stall, input int budget, output int latency);
        bit seen;
        seen    = 1'b0;
        latency = 1;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < budget && !seen; i++) begin
            applyStimulus(1'b0, 1'b0, holdStart,
                          stall ? (i % 2 == 0) : 1'b1,
                          stall ? !(i >= 13 && i <= 15) : 1'b1);
            latency++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", 0, 1);
    endtask

    // Reference model: frame phase plus an index, advanced by the handshake rules.
    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_phase = P_IDLE;
            m_idx   = 0;
            m_fc    = 0;
        end else if (abort) begin
            m_phase = P_IDLE;
            m_idx   = 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_phase = P_FILL;
                    m_idx   = 0;
                end
                P_FILL: if (deser_valid) begin
                    if (m_idx == DEPTH - 1) begin
                        m_phase = P_PROCESS;
                        m_idx   = 0;
                    end else m_idx++;
                end
                P_PROCESS: begin
                    if (m_idx == DEPTH) begin
                        m_phase = P_DRAIN;
                        m_idx   = 0;
                    end else m_idx++;
                end
                P_DRAIN: if (ser_ready) begin
                    if (m_idx == DEPTH - 1) begin
                        m_phase = P_IDLE;
                        m_idx   = 0;
                        m_done  = 1'b1;
                        m_fc    = (m_fc + 1) % 256;
                    end else m_idx++;
                end
                default: ;
            endcase
        end

        m_exp.ena    = 0;
        m_exp.rd     = 0;
        m_exp.wr     = 0;
        m_exp.chk_rd = 1'b1;
        m_exp.chk_wr = 1'b1;
        case (m_phase)
            P_FILL: begin
                m_exp.ena    = 1;
                m_exp.wr     = m_idx;
                m_exp.chk_rd = 1'b0;
            end
            P_PROCESS: begin
                m_exp.ena = 3;
                m_exp.rd  = (m_idx < DEPTH - 1) ? m_idx : DEPTH - 1;
                m_exp.wr  = (m_idx == 0) ? 0 : m_idx - 1;
            end
            P_DRAIN: begin
                m_exp.ena    = 2;
                m_exp.rd     = m_idx;
                m_exp.chk_wr = 1'b0;
            end
            default: ;
        endcase
        m_exp.busy = (m_phase != P_IDLE) ? 1 : 0;
        m_exp.done = m_done ? 1 : 0;
        m_exp.fc   = m_fc;
        expq.push_back(m_exp);
    end

    // Monitor: every cycle the DUT presents a full output set, compared against the queued expectation.
    always @(posedge clk) begin
        #1;
        if (expq.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            got = expq.pop_front();
            checkOutput("memoryena", int'(memoryena), got.ena);
            if (got.chk_rd) checkOutput("rd_addr", int'(rd_addr), got.rd);
            if (got.chk_wr) checkOutput("wr_addr", int'(wr_addr), got.wr);
            checkOutput("busy", int'(busy), got.busy);
            checkOutput("done", int'(done), got.done);
            checkOutput("frame_count", int'(frame_count), got.fc);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;

        // Reset then idle with handshakes asserted
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_memoryena", int'(memoryena), 0);
        checkOutput("reset_frame_count", int'(frame_count), 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("idle_wr_addr", int'(wr_addr), 0);

        // Continuous frame
        $display("[TB] continuous frame");
        runFrame(1'b0, 1'b0, 60, lat);
        checkOutput("latency_continuous", lat, 3 * DEPTH + 2);
        checkOutput("frames_after_first", int'(frame_count), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("done_single_pulse", int'(done), 0);

        // Stalled frame: 3 idle FILL cycles and 3 ser_ready gaps
        $display("[TB] stalled frame");
        runFrame(1'b0, 1'b1, 80, lat);
        checkOutput("latency_stalled", lat, 3 * DEPTH + 2 + (DEPTH - 1) + 3);
        checkOutput("frames_after_stall", int'(frame_count), 2);

        // Start held high: exactly one frame, then a new one right after done
        $display("[TB] held start");
        runFrame(1'b1, 1'b0, 60, lat);
        checkOutput("latency_held_start", lat, 3 * DEPTH + 2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("restart_after_done", int'(memoryena), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Abort at FILL count 2
        $display("[TB] abort during fill");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fill_count2_wr_addr", int'(wr_addr), 2);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("abort_memoryena", int'(memoryena), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_frame_count", int'(frame_count), 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("start_with_abort_idle", int'(memoryena), 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("restart_wr_addr", int'(wr_addr), 0);
        checkOutput("restart_memoryena", int'(memoryena), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        runFrame(1'b0, 1'b0, 60, lat);
        checkOutput("frames_after_abort", int'(frame_count), 4);

        // Reset during PROCESS k=2
        $display("[TB] reset mid-process");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("process_k2_rd_addr", int'(rd_addr), 2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_memoryena", int'(memoryena), 0);
        checkOutput("midreset_rd_addr", int'(rd_addr), 0);
        checkOutput("midreset_frame_count", int'(frame_count), 0);

        // Randomized traffic, judged entirely by the scoreboard
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'b0, ($urandom % 64) == 0, ($urandom % 6) == 0,
                          ($urandom % 2) == 0, ($urandom % 4) != 0);
        end

        // Frame counter wrap
        $display("[TB] frame counter wrap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 256; f++) begin
            runFrame(1'b0, 1'b0, 40, lat);
            if (f == 254) checkOutput("frame_count_255", int'(frame_count), 255);
        end
        checkOutput("frame_count_wrap", int'(frame_count), 0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
